bit_brick_seq: RTL and testbench

- Temporal BitFusion multiplier controller.
- Accepts one x/w operand pair at runtime precision (2/4/8 bit each, signed or unsigned) and sequences a single bit_brick over the 2-bit slice pairs, one brick per cycle.
- Skips pairs where either slice is zero (weight/input sparsity), and shift-accumulates into a 16-bit result.
- Sits between the PE operand registers and the systolic accumulator of the w_sparsity array.

---
 rtl/bf_pkg.sv | 29 ++
 rtl/bit_brick.sv | 21 ++
 rtl/brick_pick.sv | 17 +
 rtl/bit_brick_seq.sv | 139 +++++++++++++
 tb/tb_bit_brick_seq.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/bf_pkg.sv
// Shared types and constants for the temporal BitFusion brick sequencer.
package bf_pkg;

  localparam int ACC_W      = 16;
  localparam int BRICK_W    = 6;
  localparam int MAX_SLICES = 4;

  typedef enum logic [1:0] {
    PREC2 = 2'd0,
    PREC4 = 2'd1,
    PREC8 = 2'd2
  } prec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Reserved encoding 2'b11 falls through to the 8-bit slice count.
  function automatic logic [2:0] prec_slices(prec_t p);
    case (p)
      PREC2:   prec_slices = 3'd1;
      PREC4:   prec_slices = 3'd2;
      default: prec_slices = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/bit_brick.sv
// 2b x 2b BitFusion brick; sa/sb mark a slice as the signed top slice of its operand.
module bit_brick
  import bf_pkg::*;
(
  input  logic [1:0]         a,
  input  logic [1:0]         b,
  input  logic               sa,
  input  logic               sb,
  output logic [BRICK_W-1:0] p
);

  logic signed [2:0] a_ext;
  logic signed [2:0] b_ext;
  logic signed [BRICK_W-1:0] prod;

  assign a_ext = {sa & a[1], a};
  assign b_ext = {sb & b[1], b};
  assign prod  = BRICK_W'(a_ext) * BRICK_W'(b_ext);
  assign p     = prod;

endmodule

// File: rtl/brick_pick.sv
// Lowest-set-bit finder over the 16-entry slice-pair mask.
module brick_pick (
  input  logic [15:0] mask,
  output logic [3:0]  index,
  output logic        any
);

  always_comb begin
    index = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (mask[k]) index = 4'(k);
    end
  end

  assign any = |mask;

endmodule

// File: rtl/bit_brick_seq.sv
// Temporal BitFusion multiplier: walks nonzero x/w slice pairs through one brick,
// shift-accumulating into a 16-bit result.
module bit_brick_seq
  import bf_pkg::*;
(
  input  logic             clk,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       x,
  input  logic [7:0]       w,
  input  logic [1:0]       x_prec,
  input  logic [1:0]       w_prec,
  input  logic             x_signed,
  input  logic             w_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] product,
  output logic [4:0]       brick_cnt
);

  seq_state_t       state;
  logic [7:0]       x_r, w_r;
  logic             xs_r, ws_r;
  logic [2:0]       nx_r, nw_r;
  logic [15:0]      mask;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod_r;
  logic [4:0]       cnt;

  logic [2:0]  nx_in, nw_in;
  logic [15:0] mask_in;

  assign nx_in = prec_slices(prec_t'(x_prec));
  assign nw_in = prec_slices(prec_t'(w_prec));

  // Pair (i,j) lives at bit j*4+i; pairs beyond the precision or with a zero slice never run.
  for (genvar J = 0; J < MAX_SLICES; J++) begin : g_w
    for (genvar I = 0; I < MAX_SLICES; I++) begin : g_x
      assign mask_in[J*4+I] = (nx_in > 3'(I)) && (nw_in > 3'(J)) &&
                              (x[2*I +: 2] != 2'b00) && (w[2*J +: 2] != 2'b00);
    end
  end

  logic [3:0] k;
  logic       pick_any;

  brick_pick u_pick (
    .mask  (mask),
    .index (k),
    .any   (pick_any)
  );

  logic [1:0]         si, sj;
  logic [1:0]         xa, wb;
  logic               sx, sy;
  logic [BRICK_W-1:0] bp;

  assign si = k[1:0];
  assign sj = k[3:2];
  assign xa = x_r[{si, 1'b0} +: 2];
  assign wb = w_r[{sj, 1'b0} +: 2];
  assign sx = xs_r && ({1'b0, si} == nx_r - 3'd1);
  assign sy = ws_r && ({1'b0, sj} == nw_r - 3'd1);

  bit_brick u_brick (
    .a  (xa),
    .b  (wb),
    .sa (sx),
    .sb (sy),
    .p  (bp)
  );

  logic [2:0]       wsum;
  logic [3:0]       shamt;
  logic [ACC_W-1:0] term, acc_nxt;
  logic [15:0]      mask_nxt;

  assign wsum     = {1'b0, si} + {1'b0, sj};
  assign shamt    = {wsum, 1'b0};
  assign term     = {{(ACC_W-BRICK_W){bp[BRICK_W-1]}}, bp} << shamt;
  assign acc_nxt  = acc + term;
  assign mask_nxt = mask & ~(16'd1 << k);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      x_r    <= '0;
      w_r    <= '0;
      xs_r   <= 1'b0;
      ws_r   <= 1'b0;
      nx_r   <= '0;
      nw_r   <= '0;
      mask   <= '0;
      acc    <= '0;
      prod_r <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x_r  <= x;
          w_r  <= w;
          xs_r <= x_signed;
          ws_r <= w_signed;
          nx_r <= nx_in;
          nw_r <= nw_in;
          mask <= mask_in;
          acc  <= '0;
          cnt  <= '0;
          if (mask_in != '0) state <= RUN;
          else begin
            state  <= DONE;
            prod_r <= '0;
          end
        end
        RUN: if (pick_any) begin
          acc  <= acc_nxt;
          cnt  <= cnt + 5'd1;
          mask <= mask_nxt;
          if (mask_nxt == '0) begin
            state  <= DONE;
            prod_r <= acc_nxt;
          end
        end else begin
          state  <= DONE;
          prod_r <= acc;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign product   = prod_r;
  assign brick_cnt = cnt;

endmodule

// File: tb/tb_bit_brick_seq.sv
// Directed + randomized checks of bit_brick_seq against an arithmetic reference model.
module tb_bit_brick_seq;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  x = '0, w = '0;
  logic [1:0]  x_prec = '0, w_prec = '0;
  logic        x_signed = 1'b0, w_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] product;
  logic [4:0]  brick_cnt;

  int n_checks = 0;
  int n_fail = 0;

  bit_brick_seq dut (
    .clk(clk), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .w(w), .x_prec(x_prec), .w_prec(w_prec),
    .x_signed(x_signed), .w_signed(w_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .brick_cnt(brick_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int prec_bits(input logic [1:0] p);
    return (p == 2'd0) ? 2 : (p == 2'd1) ? 4 : 8;
  endfunction

  // Operand value as a plain integer at its runtime precision.
  function automatic int sval(input logic [7:0] v, input logic [1:0] p, input logic s);
    int b = prec_bits(p);
    int m = int'(v) & ((1 << b) - 1);
    if (s && m >= (1 << (b - 1))) m -= (1 << b);
    return m;
  endfunction

  function automatic int nz_slices(input logic [7:0] v, input logic [1:0] p);
    int n = 0;
    for (int s = 0; s < prec_bits(p) / 2; s++)
      if (((int'(v) >> (2 * s)) & 3) != 0) n++;
    return n;
  endfunction

  task automatic run_op(input logic [7:0] xi, input logic [7:0] wi,
                        input logic [1:0] xp, input logic [1:0] wp,
                        input logic xs, input logic ws, input int hold,
                        output logic [15:0] got_p, output logic [4:0] got_n);
    int ex_n, cyc;
    logic [15:0] ex_p;
    ex_n = nz_slices(xi, xp) * nz_slices(wi, wp);
    ex_p = 16'(sval(xi, xp, xs) * sval(wi, wp, ws));
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    x = xi; w = wi; x_prec = xp; w_prec = wp; x_signed = xs; w_signed = ws;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 8'($urandom); w = 8'($urandom); x_prec = 2'($urandom); w_prec = 2'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(ex_n + 1));
    check("product", 32'(product), 32'(ex_p));
    check("brick_cnt", 32'(brick_cnt), 32'(ex_n));
    got_p = product;
    got_n = brick_cnt;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      x = 8'($urandom); w = 8'($urandom);
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_product", 32'(product), 32'(ex_p));
      check("hold_cnt", 32'(brick_cnt), 32'(ex_n));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ret_in_ready", 32'(in_ready), 32'd1);
    check("ret_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] p;
    logic [4:0]  n;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_cnt", 32'(brick_cnt), 32'd0);
    @(negedge clk); nRST = 1'b1;

    // 8b x 8b unsigned, all 16 pairs
    run_op(8'hFF, 8'hFF, 2'd2, 2'd2, 1'b0, 1'b0, 0, p, n);
    check("ff_ff_product", 32'(p), 32'h0000_FE01);
    check("ff_ff_cnt", 32'(n), 32'd16);

    // signed -128 * 2, single pair
    run_op(8'h80, 8'h02, 2'd2, 2'd2, 1'b1, 1'b1, 0, p, n);
    check("m128x2_product", 32'(p), 32'h0000_FF00);
    check("m128x2_cnt", 32'(n), 32'd1);

    // 4b signed -3 * unsigned 5
    run_op(8'h0D, 8'h05, 2'd1, 2'd1, 1'b1, 1'b0, 0, p, n);
    check("m3x5_product", 32'(p), 32'h0000_FFF1);

    // empty mask
    run_op(8'h5A, 8'h00, 2'd2, 2'd2, 1'b0, 1'b0, 0, p, n);
    check("sparse_product", 32'(p), 32'd0);
    check("sparse_cnt", 32'(n), 32'd0);

    // 2b signed -2 * unsigned 3, upper garbage bits ignored
    run_op(8'hF2, 8'hA3, 2'd0, 2'd0, 1'b1, 1'b0, 0, p, n);
    check("m2x3_product", 32'(p), 32'h0000_FFFA);

    // backpressure with ignored in_valid pulses
    run_op(8'h37, 8'hC9, 2'd2, 2'd2, 1'b1, 1'b0, 5, p, n);

    // reset during RUN cycle 3 of FF*FF
    @(negedge clk);
    x = 8'hFF; w = 8'hFF; x_prec = 2'd2; w_prec = 2'd2; x_signed = 1'b0; w_signed = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nRST = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_cnt", 32'(brick_cnt), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); nRST = 1'b1;
    run_op(8'h07, 8'h09, 2'd2, 2'd2, 1'b0, 1'b0, 0, p, n);
    check("post_rst_product", 32'(p), 32'h0000_003F);

    // reserved precision behaves as 8b
    run_op(8'hB5, 8'h6E, 2'd3, 2'd3, 1'b1, 1'b1, 0, p, n);

    // randomized operations against the model
    for (int r = 0; r < 60; r++) begin
      run_op(8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
             1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), p, n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
